// File: rtl/fp_pkg.sv
// Shared FPU types and helpers for the adder, multiplier and divider datapaths.
// Width-generic helpers work on 64-bit containers; callers slice to their word width.
package fp_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RUP = 3'd2,
    RDN = 3'd3,
    RNA = 3'd4
  } round_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    NORM = 3'd2,
    INF  = 3'd3,
    NAN  = 3'd4
  } fp_class_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic fp_class_t fp_classify(input logic [63:0] e, input logic [63:0] f,
                                            input int exp_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    if (e == 64'd0) return (f == 64'd0) ? ZERO : SUB;
    if (e == ones)  return (f == 64'd0) ? INF : NAN;
    return NORM;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
    return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

  function automatic logic [63:0] fp_max_finite(input int exp_w, input int frac_w);
    return (((64'd1 << exp_w) - 64'd2) << frac_w) | ((64'd1 << frac_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounder/packer: rounding, overflow saturation and underflow handling.
// FP_DIV_SUBNORMAL_EN selects gradual underflow; otherwise tiny results flush to zero.
module fp_round
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_b,
  input  logic [FRAC_W:0]         mant,
  input  logic                    guard,
  input  logic                    sticky,
  input  round_t                  mode,
  output logic [EXP_W+FRAC_W:0]   z,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [63:0] MAXF = fp_max_finite(EXP_W, FRAC_W);
  localparam logic signed [EXP_W+1:0] ZERO_S = '0;
  localparam logic signed [EXP_W+1:0] ONE_S  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] EMAX_S = {2'b00, {EXP_W{1'b1}}};

  logic                    tiny, g_r, s_r, inc, max_sel;
  logic [FRAC_W:0]         m_r;
  logic [FRAC_W+1:0]       mr;
  logic signed [EXP_W+1:0] exp_r;
`ifdef FP_DIV_SUBNORMAL_EN
  logic [2*FRAC_W+3:0]     wide;
  logic signed [EXP_W+1:0] sh_s;
  int                      sh;
`endif

  always_comb begin
    tiny = (exp_b <= ZERO_S);
    m_r  = mant;
    g_r  = guard;
    s_r  = sticky;
`ifdef FP_DIV_SUBNORMAL_EN
    // denormalise: shift right by 1-exp, everything shifted past guard lands in sticky
    sh_s = ONE_S - exp_b;
    sh   = tiny ? int'(sh_s) : 0;
    if (sh > FRAC_W + 3) sh = FRAC_W + 3;
    wide = {mant, guard, {(FRAC_W+2){1'b0}}} >> sh;
    if (tiny) begin
      m_r = wide[2*FRAC_W+3 -: FRAC_W+1];
      g_r = wide[FRAC_W+2];
      s_r = sticky | (|wide[FRAC_W+1:0]);
    end
`endif
    case (mode)
      RTZ:     inc = 1'b0;
      RUP:     inc = ~sign & (g_r | s_r);
      RDN:     inc = sign & (g_r | s_r);
      RNA:     inc = g_r;
      default: inc = g_r & (s_r | m_r[0]);
    endcase
    mr = {1'b0, m_r} + {{(FRAC_W+1){1'b0}}, inc};
    // integer part of the rounded significand is 1 or 2; a 2 bumps the exponent
    exp_r = exp_b - ONE_S + $signed({{EXP_W{1'b0}}, mr[FRAC_W+1:FRAC_W]});
    max_sel   = (mode == RTZ) || (mode == RUP && sign) || (mode == RDN && !sign);
    inexact   = g_r | s_r;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (tiny) begin
`ifdef FP_DIV_SUBNORMAL_EN
      z         = {sign, {(EXP_W-1){1'b0}}, mr[FRAC_W], mr[FRAC_W-1:0]};
      underflow = g_r | s_r;
`else
      z         = {sign, {(W-1){1'b0}}};
      underflow = 1'b1;
      inexact   = 1'b1;
`endif
    end else if (exp_r >= EMAX_S) begin
      overflow = 1'b1;
      inexact  = 1'b1;
      z = max_sel ? {sign, MAXF[W-2:0]} : {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      z = {sign, exp_r[EXP_W-1:0], mr[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 divider, radix-2 non-restoring recurrence, one quotient bit per cycle.
// FP_DIV_SUBNORMAL_EN enables subnormal operands and gradual underflow.
module fp_divider_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_ready_i,
  input  round_t                rounding_mode_i,
  input  logic [EXP_W+FRAC_W:0] x_i,
  input  logic [EXP_W+FRAC_W:0] y_i,
  output logic                  busy_o,
  output logic                  data_valid_o,
  output logic [EXP_W+FRAC_W:0] z_o,
  output logic                  except_invalid_operation_o,
  output logic                  except_div_by_zero_o,
  output logic                  except_overflow_o,
  output logic                  except_underflow_o,
  output logic                  except_inexact_o
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int QW = FRAC_W + 3;
  localparam int CW = $clog2(QW);
  localparam logic [2:0] S_IDLE = 3'd0, S_UNPACK = 3'd1, S_DIVIDE = 3'd2, S_ROUND = 3'd3,
                         S_DONE = 3'd4;
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
  localparam logic signed [EXP_W+1:0] BIAS_S = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] ONE_S  = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, FRAC_W);

  logic [2:0]              state;
  logic [W-1:0]            x_q, y_q, res_z;
  round_t                  mode_q;
  logic signed [EXP_W+1:0] exp_q;
  logic [FRAC_W:0]         my_q;
  logic signed [QW-1:0]    rem_q;
  logic [QW-1:0]           quo_q;
  logic [CW-1:0]           cnt_q;
  fp_flags_t               res_flags, flags_q;

  logic                    sgn, sp_hit;
  logic [EXP_W-1:0]        xe, ye;
  logic [FRAC_W-1:0]       xf, yf;
  fp_class_t               cx, cy;
  logic [W-1:0]            sp_z;
  fp_flags_t               sp_flags;
  logic [FRAC_W:0]         mx, my;
  logic signed [EXP_W+1:0] ex, ey;

`ifdef FP_DIV_SUBNORMAL_EN
  function automatic int lzc(input logic [FRAC_W-1:0] f);
    int n;
    n = FRAC_W;
    for (int i = 0; i < FRAC_W; i++) if (f[i]) n = FRAC_W - 1 - i;
    return n;
  endfunction
`endif

  always_comb begin
    sgn = x_q[W-1] ^ y_q[W-1];
    xe  = x_q[W-2:FRAC_W];
    ye  = y_q[W-2:FRAC_W];
    xf  = x_q[FRAC_W-1:0];
    yf  = y_q[FRAC_W-1:0];
    cx  = fp_classify(64'(xe), 64'(xf), EXP_W);
    cy  = fp_classify(64'(ye), 64'(yf), EXP_W);
    mx  = {1'b1, xf};
    my  = {1'b1, yf};
    ex  = $signed({2'b00, xe});
    ey  = $signed({2'b00, ye});
`ifdef FP_DIV_SUBNORMAL_EN
    // subnormal: shift the leading one into the hidden position, exponent becomes -lz
    if (cx == SUB) begin
      mx = {1'b0, xf} << (lzc(xf) + 1);
      ex = (EXP_W+2)'(-lzc(xf));
    end
    if (cy == SUB) begin
      my = {1'b0, yf} << (lzc(yf) + 1);
      ey = (EXP_W+2)'(-lzc(yf));
    end
`else
    if (cx == SUB) cx = ZERO;
    if (cy == SUB) cy = ZERO;
`endif
    sp_hit   = 1'b1;
    sp_flags = '0;
    sp_z     = {sgn, {(W-1){1'b0}}};
    if (cx == NAN || cy == NAN || (cx == ZERO && cy == ZERO) || (cx == INF && cy == INF)) begin
      sp_z             = QNAN64[W-1:0];
      sp_flags.invalid = 1'b1;
    end else if (cy == ZERO && cx != INF) begin
      sp_z                 = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      sp_flags.div_by_zero = 1'b1;
    end else if (cx == ZERO || cy == INF) begin
      sp_z = {sgn, {(W-1){1'b0}}};
    end else if (cx == INF) begin
      sp_z = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic signed [QW-1:0]    my_ext, base, rem_n, rem_fix;
  logic [QW-1:0]           quo_n;
  logic [FRAC_W:0]         rm_mant;
  logic                    rm_g, rm_s;
  logic signed [EXP_W+1:0] rm_exp;
  logic [W-1:0]            rnd_z;
  logic                    rnd_ovf, rnd_unf, rnd_inx;

  always_comb begin
    my_ext = $signed({2'b00, my_q});
    // first step works on the unshifted dividend so bit 0 is the integer quotient bit
    base   = (cnt_q == '0) ? rem_q : (rem_q <<< 1);
    rem_n  = rem_q[QW-1] ? (base + my_ext) : (base - my_ext);
    quo_n  = {quo_q[QW-2:0], ~rem_n[QW-1]};
    rem_fix = rem_q[QW-1] ? (rem_q + my_ext) : rem_q;
    if (quo_q[QW-1]) begin
      rm_mant = quo_q[QW-1:2];
      rm_g    = quo_q[1];
      rm_s    = quo_q[0] | (|rem_fix);
      rm_exp  = exp_q;
    end else begin
      rm_mant = quo_q[QW-2:1];
      rm_g    = quo_q[0];
      rm_s    = |rem_fix;
      rm_exp  = exp_q - ONE_S;
    end
  end

  fp_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .sign      (sgn),
    .exp_b     (rm_exp),
    .mant      (rm_mant),
    .guard     (rm_g),
    .sticky    (rm_s),
    .mode      (mode_q),
    .z         (rnd_z),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf),
    .inexact   (rnd_inx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= RNE;
      exp_q        <= '0;
      my_q         <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      res_z        <= '0;
      res_flags    <= '0;
      flags_q      <= '0;
      z_o          <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      case (state)
        S_IDLE: if (data_ready_i) begin
          x_q    <= x_i;
          y_q    <= y_i;
          mode_q <= rounding_mode_i;
          state  <= S_UNPACK;
        end
        S_UNPACK: if (sp_hit) begin
          res_z     <= sp_z;
          res_flags <= sp_flags;
          state     <= S_DONE;
        end else begin
          exp_q <= ex - ey + BIAS_S;
          my_q  <= my;
          rem_q <= $signed({2'b00, mx});
          quo_q <= '0;
          cnt_q <= '0;
          state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state <= S_ROUND;
        end
        S_ROUND: begin
          res_z     <= rnd_z;
          res_flags <= {2'b00, rnd_ovf, rnd_unf, rnd_inx};
          state     <= S_DONE;
        end
        S_DONE: begin
          z_o          <= res_z;
          flags_q      <= res_flags;
          data_valid_o <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o                     = (state != S_IDLE);
  assign except_invalid_operation_o = flags_q.invalid;
  assign except_div_by_zero_o       = flags_q.div_by_zero;
  assign except_overflow_o          = flags_q.overflow;
  assign except_underflow_o         = flags_q.underflow;
  assign except_inexact_o           = flags_q.inexact;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Scoreboard bench for fp_divider_seq (FP32); expectations follow FP_DIV_SUBNORMAL_EN.
module tb_fp_divider_seq;
  import fp_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, dr = 1'b0;
  round_t      mode = RNE;
  logic [31:0] x = '0, y = '0;
  logic        busy, vld, inv, dbz, ovf, unf, inx;
  logic [31:0] z;

  int checks = 0, errors = 0, edge_cnt = 0, done_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] z;
    logic [4:0]  f;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  fp_divider_seq #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .data_ready_i               (dr),
    .rounding_mode_i            (mode),
    .x_i                        (x),
    .y_i                        (y),
    .busy_o                     (busy),
    .data_valid_o               (vld),
    .z_o                        (z),
    .except_invalid_operation_o (inv),
    .except_div_by_zero_o       (dbz),
    .except_overflow_o          (ovf),
    .except_underflow_o         (unf),
    .except_inexact_o           (inx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && vld) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk({e.tag, ":z"}, z, e.z);
        chk({e.tag, ":flags"}, {inv, dbz, ovf, unf, inx}, e.f);
        chk({e.tag, ":lat"}, edge_cnt - e.acc, e.lat);
        chk({e.tag, ":busy_lo"}, busy, 0);
      end
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic run(input string tag, input logic [31:0] xa, input logic [31:0] ya,
                     input round_t m, input logic [31:0] ez, input logic [4:0] ef,
                     input int lat, input bit noise);
    int   d0;
    exp_t e;
    @(negedge clk);
    d0 = done_cnt;
    x = xa; y = ya; mode = m; dr = 1'b1;
    e.tag = tag; e.z = ez; e.f = ef; e.acc = edge_cnt + 1; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    dr = 1'b0;
    chk({tag, ":busy_hi"}, busy, 1);
    if (noise) begin
      repeat (3) @(negedge clk);
      x = 32'h3F800000; y = 32'h0; mode = RTZ; dr = 1'b1;
      repeat (2) @(negedge clk);
      dr = 1'b0;
    end
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) begin
      chk({tag, ":timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst:z", z, 0);
    chk("rst:busy", busy, 0);
    chk("rst:vld", vld, 0);
    chk("rst:flags", {inv, dbz, ovf, unf, inx}, 0);
    rst = 1'b0;

    // flags = {invalid, div_by_zero, overflow, underflow, inexact}
    run("6div3",     32'h40C00000, 32'h40400000, RNE, 32'h40000000, 5'b00000, 29, 0);
    run("1div3_rne", 32'h3F800000, 32'h40400000, RNE, 32'h3EAAAAAB, 5'b00001, 29, 0);
    run("1div3_rtz", 32'h3F800000, 32'h40400000, RTZ, 32'h3EAAAAAA, 5'b00001, 29, 0);
    run("1div3_rup", 32'h3F800000, 32'h40400000, RUP, 32'h3EAAAAAB, 5'b00001, 29, 0);
    run("1div3_rna", 32'h3F800000, 32'h40400000, RNA, 32'h3EAAAAAB, 5'b00001, 29, 0);
    run("m1div3_rdn", 32'hBF800000, 32'h40400000, RDN, 32'hBEAAAAAB, 5'b00001, 29, 0);
    run("m1div3_rup", 32'hBF800000, 32'h40400000, RUP, 32'hBEAAAAAA, 5'b00001, 29, 0);
    run("1div0",     32'h3F800000, 32'h00000000, RNE, 32'h7F800000, 5'b01000, 2, 0);
    run("0div0",     32'h00000000, 32'h00000000, RNE, 32'h7FC00000, 5'b10000, 2, 0);
    run("ninf_div2", 32'hFF800000, 32'h40000000, RNE, 32'hFF800000, 5'b00000, 2, 0);
    run("nan_div1",  32'h7FC00001, 32'h3F800000, RNE, 32'h7FC00000, 5'b10000, 2, 0);
    run("inf_inf",   32'h7F800000, 32'hFF800000, RNE, 32'h7FC00000, 5'b10000, 2, 0);
    run("nz_div2",   32'h80000000, 32'h40000000, RNE, 32'h80000000, 5'b00000, 2, 0);
    run("1div_inf",  32'h3F800000, 32'h7F800000, RNE, 32'h00000000, 5'b00000, 2, 0);
    run("ovf_rne",   32'h7F7FFFFF, 32'h3F000000, RNE, 32'h7F800000, 5'b00101, 29, 0);
    run("ovf_rtz",   32'h7F7FFFFF, 32'h3F000000, RTZ, 32'h7F7FFFFF, 5'b00101, 29, 0);
    run("novf_rup",  32'hFF7FFFFF, 32'h3F000000, RUP, 32'hFF7FFFFF, 5'b00101, 29, 0);
    run("novf_rdn",  32'hFF7FFFFF, 32'h3F000000, RDN, 32'hFF800000, 5'b00101, 29, 0);
`ifdef FP_DIV_SUBNORMAL_EN
    run("tiny",      32'h00800000, 32'h40000000, RNE, 32'h00400000, 5'b00000, 29, 0);
    run("sub_in",    32'h00400000, 32'h3F800000, RNE, 32'h00400000, 5'b00000, 29, 0);
`else
    run("tiny",      32'h00800000, 32'h40000000, RNE, 32'h00000000, 5'b00011, 29, 0);
    run("sub_in",    32'h00400000, 32'h3F800000, RNE, 32'h00000000, 5'b00000, 2, 0);
`endif
    run("noise",     32'h40C00000, 32'h40400000, RNE, 32'h40000000, 5'b00000, 29, 1);

    // abort mid-divide: no pulse, everything back to zero at once
    @(negedge clk);
    x = 32'h3F800000; y = 32'h40400000; mode = RNE; dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort:z", z, 0);
    chk("abort:busy", busy, 0);
    chk("abort:vld", vld, 0);
    chk("abort:flags", {inv, dbz, ovf, unf, inx}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run("after_rst", 32'h40C00000, 32'h40400000, RNE, 32'h40000000, 5'b00000, 29, 0);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_divider_seq.md
# fp_divider_seq

Parametrised IEEE-754 binary floating-point divider using a radix-2 non-restoring mantissa recurrence. It is the successor to the Newton-Raphson divider in the FPU datapath. It needs no shared multiplier or adder, takes configurable exponent and fraction widths, honours all rounding modes, and raises a full exception set. It sits beside the adder and multiplier behind the FPU operation decode and uses the same start/valid handshake.

## Interface
- `EXP_W`, default 8: exponent field width.
- `FRAC_W`, default 23: stored fraction width. Word width is `W = 1 + EXP_W + FRAC_W`.
- `clk_i`, input, 1: the block's only clock.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `data_ready_i`, input, 1: start request, sampled only in IDLE.
- `rounding_mode_i`, input, 3: `fp_pkg::round_t`. Encodings: RNE=0, RTZ=1, RUP=2, RDN=3, RNA=4.
- `x_i`, input, W: dividend.
- `y_i`, input, W: divisor.
- `busy_o`, output, 1: high in every state except IDLE.
- `data_valid_o`, output, 1: one-cycle pulse when the result is ready.
- `z_o`, output, W: quotient, held until the next start.
- `except_invalid_operation_o`, `except_div_by_zero_o`, `except_overflow_o`, `except_underflow_o`, `except_inexact_o`, outputs, 1 each: held with `z_o`.

## Operation
- States: IDLE → UNPACK → DIVIDE → ROUND → DONE → IDLE. UNPACK jumps straight to DONE for special operands.
- IDLE accepts when `data_ready_i`=1 and latches the operands and rounding mode. `data_ready_i` is ignored in every other state.
- UNPACK classifies each operand, with priority from top to bottom:
  - Any NaN, 0/0 or ∞/∞: canonical qNaN, i.e. sign 0, exponent all ones, fraction MSB 1, rest 0. Sets invalid.
  - Finite/0: signed ∞. Sets div_by_zero.
  - 0/finite or finite/∞: signed 0.
  - ∞/finite: signed ∞.
- In all special cases sign = `sx ^ sy`, except the qNaN.
- Normal path setup:
  - Significands `mx`, `my` are FRAC_W+1 bits with the hidden bit.
  - Exponent is `ex − ey + BIAS`, computed in signed EXP_W+2 bits.
- DIVIDE: one quotient bit per cycle for FRAC_W+3 cycles. The partial remainder is FRAC_W+3 bits, two's complement.
- ROUND:
  - Apply the final remainder correction. Sticky = remainder ≠ 0.
  - If the quotient MSB is 0, shift left by 1 and decrement the exponent.
  - Round with guard and sticky per mode. A mantissa carry-out increments the exponent.
- Overflow (biased exponent ≥ 2^EXP_W−1) sets overflow and inexact. Result per mode:
  - RTZ: max finite.
  - RUP: +∞ for positive results, max finite for negative.
  - RDN: −∞ for negative results, max finite for positive.
  - RNE, RNA: ∞.
- Underflow (biased exponent ≤ 0) is handled per Configuration. Underflow is flagged only when the result is tiny and inexact.
- `except_inexact_o` = guard | sticky on the normal path.
- DONE: register the result and flags and pulse `data_valid_o`.

## Timing
- Reset (async): state IDLE. `busy_o`, `data_valid_o`, `z_o` and all flags are 0. Reset applied mid-operation aborts immediately and no pulse is produced.
- Normal-path latency: `data_valid_o` goes high FRAC_W+6 edges after the accepting edge. That is 29 for FP32.
- Special-case latency: 2 edges.
- `busy_o` rises the edge after acceptance and falls together with `data_valid_o`.
- The earliest next accept is the edge after DONE, so back-to-back FP32 throughput is 1 operation per 30 cycles.

## Configuration
- Macro: `FP_DIV_SUBNORMAL_EN`.
- Defined:
  - UNPACK normalises subnormal inputs with a leading-zero count and adjusts the exponent. This stays within the one UNPACK cycle.
  - ROUND denormalises tiny results by right-shifting into guard and sticky before rounding, giving gradual underflow.
- Undefined:
  - Subnormal inputs are treated as signed zero.
  - Tiny results flush to signed zero with underflow and inexact set.
- Latency is identical in both builds.

## Structure
- `fp_pkg` holds:
  - `round_t`.
  - `fp_class_t` (ZERO, SUB, NORM, INF, NAN).
  - The classify function, parametrised on widths.
  - Canonical-NaN and max-finite constant functions.
- `fp_pkg` is shared with the adder and multiplier.
- Sub-module `fp_round`: combinational round, overflow and underflow packer, taking sign, exponent, mantissa, guard, sticky and mode. It is reused by the adder and multiplier.

## Test plan
1. FP32: 0x40C00000 / 0x40400000, RNE → z=0x40000000, no flags, `data_valid_o` at edge 29.
2. 0x3F800000 / 0x40400000 → RNE gives 0x3EAAAAAB; RTZ gives 0x3EAAAAAA; both set inexact.
3. Specials:
   - 0x3F800000 / 0 → 0x7F800000 with div_by_zero.
   - 0/0 → 0x7FC00000 with invalid.
   - 0xFF800000 / 0x40000000 → 0xFF800000, no flags.
   - All complete in 2 edges.
4. 0x7F7FFFFF / 0x3F000000 → RNE gives 0x7F800000; RTZ gives 0x7F7FFFFF; both set overflow and inexact.
5. 0x00800000 / 0x40000000 → with macro, 0x00400000 and no flags; without macro, 0x00000000 with underflow and inexact.
6. Assert `rst_i` at DIVIDE cycle 10 → outputs 0 immediately. Pulsing `data_ready_i` while busy is ignored. A following 6/3 still returns 0x40000000.
